// File: rtl/ex_stage_if.sv
// ex_stage_if: ID->EX operand bus and EX->ID/MEM result bus for the execute stage
`ifndef EX_OP_BUS
`define EX_OP_BUS 5:0
`endif
`ifndef WORD_BUS
`define WORD_BUS 31:0
`endif
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef REG_ZERO
`define REG_ZERO 5'd0
`endif

interface ex_stage_if;
    logic [`EX_OP_BUS]    i_exop;
    logic [`WORD_BUS]     i_srcLeft;
    logic [`WORD_BUS]     i_srcRight;
    logic [`WORD_BUS]     i_offset;
    logic [`REG_ADDR_BUS] i_dest;
    logic                 i_stall;
    logic [`REG_ADDR_BUS] o_exDest;
    logic [`WORD_BUS]     o_exResult;
    logic                 o_exWriteEnable;
    logic [`REG_ADDR_BUS] o_memDest;
    logic [`WORD_BUS]     o_memResult;
    logic                 o_busy;

    modport master (
        output i_exop, i_srcLeft, i_srcRight, i_offset, i_dest, i_stall,
        input  o_exDest, o_exResult, o_exWriteEnable, o_memDest, o_memResult, o_busy
    );

    modport slave (
        input  i_exop, i_srcLeft, i_srcRight, i_offset, i_dest, i_stall,
        output o_exDest, o_exResult, o_exWriteEnable, o_memDest, o_memResult, o_busy
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage -- logic/arith/shift ALU, HI/LO, single-cycle multiplier,
// optional 32-cycle restoring divider (define EX_DIV_EN), and the EX->MEM register.
// Op encoding {group[5:3], op[2:0]}: 1=logic{OR,AND,XOR,NOR} 2=arith{ADDU,SUBU,SLT,SLTU}
// 3=shift{SLL,SRL,SRA} 4=hilo{MFHI,MFLO,MTHI,MTLO} 5=muldiv{MULT,MULTU,DIV,DIVU}.
`ifndef EX_OP_BUS
`define EX_OP_BUS 5:0
`endif
`ifndef WORD_BUS
`define WORD_BUS 31:0
`endif
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef REG_ZERO
`define REG_ZERO 5'd0
`endif

module ex_stage (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave io_bus
);
    localparam logic [2:0] G_LOGIC = 3'd1, G_ARITH = 3'd2, G_SHIFT = 3'd3, G_HILO = 3'd4, G_MULDIV = 3'd5;

    logic [`EX_OP_BUS]    r_exop;
    logic [`WORD_BUS]     r_srcLeft, r_srcRight, r_offset, r_hi, r_lo, r_memResult;
    logic [`REG_ADDR_BUS] r_dest, r_memDest;
    logic [2:0]           w_grp, w_op;
    logic [`WORD_BUS]     w_result, w_sra, w_slt, w_sltu, w_div_hi, w_div_lo;
    logic [63:0]          w_prod_s, w_prod_u;
    logic                 w_we, w_busy, w_div_done, w_unused_offset;

    assign w_grp    = r_exop[5:3];
    assign w_op     = r_exop[2:0];
    assign w_sra    = $signed(r_srcRight) >>> r_srcLeft[4:0];
    assign w_slt    = {31'd0, $signed(r_srcLeft) < $signed(r_srcRight)};
    assign w_sltu   = {31'd0, r_srcLeft < r_srcRight};
    assign w_prod_s = {{32{r_srcLeft[31]}}, r_srcLeft} * {{32{r_srcRight[31]}}, r_srcRight};
    assign w_prod_u = {32'd0, r_srcLeft} * {32'd0, r_srcRight};
    // offset travels with the instruction but no op in this stage consumes it yet
    assign w_unused_offset = ^r_offset;

    // Result mux for the op held in EX; anything unrecognised is a non-writing zero
    always_comb begin
        w_result = '0;
        w_we     = 1'b0;
        case (w_grp)
            G_LOGIC: begin
                w_we     = ~w_op[2];
                w_result = w_op == 3'd0 ? (r_srcLeft | r_srcRight) :
                           w_op == 3'd1 ? (r_srcLeft & r_srcRight) :
                           w_op == 3'd2 ? (r_srcLeft ^ r_srcRight) :
                           w_op == 3'd3 ? ~(r_srcLeft | r_srcRight) : '0;
            end
            G_ARITH: begin
                w_we     = ~w_op[2];
                w_result = w_op == 3'd0 ? r_srcLeft + r_srcRight :
                           w_op == 3'd1 ? r_srcLeft - r_srcRight :
                           w_op == 3'd2 ? w_slt :
                           w_op == 3'd3 ? w_sltu : '0;
            end
            G_SHIFT: begin
                w_we     = w_op < 3'd3;
                w_result = w_op == 3'd0 ? r_srcRight << r_srcLeft[4:0] :
                           w_op == 3'd1 ? r_srcRight >> r_srcLeft[4:0] :
                           w_op == 3'd2 ? w_sra : '0;
            end
            G_HILO: begin
                w_we     = w_op < 3'd2;
                w_result = w_op == 3'd0 ? r_hi : w_op == 3'd1 ? r_lo : '0;
            end
            default: ;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

    div_state_t       r_state;
    logic [4:0]       r_cnt;
    logic [`WORD_BUS] r_quo, r_rem, r_dvs;
    logic             r_neg_q, r_neg_r;
    logic             w_div_start, w_signed;
    logic [32:0]      w_trial;

    // busy rises combinationally in the cycle the divide enters EX so that cycle's input is held
    assign w_signed    = w_op == 3'd2;
    assign w_div_start = r_state == S_IDLE && w_grp == G_MULDIV && w_op[2:1] == 2'b01 && r_srcRight != '0;
    assign w_busy      = w_div_start || r_state == S_RUN;
    assign w_div_done  = r_state == S_DONE;
    assign w_trial     = {r_rem, r_quo[31]} - {1'b0, r_dvs};
    assign w_div_lo    = r_neg_q ? -r_quo : r_quo;
    assign w_div_hi    = r_neg_r ? -r_rem : r_rem;

    // Divider FSM: capture magnitudes, shift-subtract one quotient bit per cycle, then hand off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_div_start) begin
                    r_quo   <= (w_signed && r_srcLeft[31]) ? -r_srcLeft : r_srcLeft;
                    r_dvs   <= (w_signed && r_srcRight[31]) ? -r_srcRight : r_srcRight;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_neg_q <= w_signed && (r_srcLeft[31] ^ r_srcRight[31]);
                    r_neg_r <= w_signed && r_srcLeft[31];
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_rem   <= w_trial[32] ? {r_rem[30:0], r_quo[31]} : w_trial[31:0];
                    r_quo   <= {r_quo[30:0], ~w_trial[32]};
                    r_cnt   <= r_cnt + 5'd1;
                    r_state <= r_cnt == 5'd31 ? S_DONE : S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_busy     = 1'b0;
    assign w_div_done = 1'b0;
    assign w_div_hi   = '0;
    assign w_div_lo   = '0;
`endif

    // EX input register: hold while the divider runs, insert a bubble on an ID stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exop     <= '0;
            r_srcLeft  <= '0;
            r_srcRight <= '0;
            r_offset   <= '0;
            r_dest     <= `REG_ZERO;
        end else if (!w_busy) begin
            r_exop     <= io_bus.i_stall ? '0 : io_bus.i_exop;
            r_srcLeft  <= io_bus.i_stall ? '0 : io_bus.i_srcLeft;
            r_srcRight <= io_bus.i_stall ? '0 : io_bus.i_srcRight;
            r_offset   <= io_bus.i_stall ? '0 : io_bus.i_offset;
            r_dest     <= io_bus.i_stall ? `REG_ZERO : io_bus.i_dest;
        end
    end

    // HI/LO: divider completion first, otherwise the multiply or move op currently in EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_done) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
        end else if (w_grp == G_MULDIV && w_op[2:1] == 2'b00) begin
            {r_hi, r_lo} <= w_op[0] ? w_prod_u : w_prod_s;
        end else if (w_grp == G_HILO && w_op == 3'd2) begin
            r_hi <= r_srcLeft;
        end else if (w_grp == G_HILO && w_op == 3'd3) begin
            r_lo <= r_srcLeft;
        end
    end

    // MEM register: forward only writing results, and a bubble while the divider is busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memDest   <= `REG_ZERO;
            r_memResult <= '0;
        end else begin
            r_memDest   <= (!w_busy && w_we) ? r_dest : `REG_ZERO;
            r_memResult <= w_busy ? '0 : w_result;
        end
    end

    assign io_bus.o_exDest        = w_we ? r_dest : `REG_ZERO;
    assign io_bus.o_exResult      = w_result;
    assign io_bus.o_exWriteEnable = w_we;
    assign io_bus.o_memDest       = r_memDest;
    assign io_bus.o_memResult     = r_memResult;
    assign io_bus.o_busy          = w_busy;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random instruction stream for ex_stage against a behavioural model
module tb_ex_stage;
    localparam logic [5:0] OP_NOP  = 6'o00, OP_OR   = 6'o10, OP_AND  = 6'o11, OP_XOR  = 6'o12, OP_NOR = 6'o13;
    localparam logic [5:0] OP_ADDU = 6'o20, OP_SUBU = 6'o21, OP_SLT  = 6'o22, OP_SLTU = 6'o23;
    localparam logic [5:0] OP_SLL  = 6'o30, OP_SRL  = 6'o31, OP_SRA  = 6'o32;
    localparam logic [5:0] OP_MFHI = 6'o40, OP_MFLO = 6'o41, OP_MTHI = 6'o42, OP_MTLO = 6'o43;
    localparam logic [5:0] OP_MULT = 6'o50, OP_MULTU = 6'o51, OP_DIV = 6'o52, OP_DIVU = 6'o53;
    localparam logic [5:0] OPS [0:21] = '{OP_NOP, OP_OR, OP_AND, OP_XOR, OP_NOR, OP_ADDU, OP_SUBU,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT,
        OP_MULTU, OP_DIV, OP_DIVU, 6'o07, 6'o37};
`ifdef EX_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .io_bus(bus));

    int          n_vec = 0, n_chk = 0, n_err = 0;
    logic [31:0] m_hi = 0, m_lo = 0, exp_mres = 0;
    logic [4:0]  exp_mdest = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of an op given the model's HI/LO
    function automatic void model(input logic [5:0] op, input logic [31:0] l, input logic [31:0] r,
                                  output logic we, output logic [31:0] res);
        we  = 1'b1;
        res = 32'd0;
        case (op)
            OP_OR:   res = l | r;
            OP_AND:  res = l & r;
            OP_XOR:  res = l ^ r;
            OP_NOR:  res = ~(l | r);
            OP_ADDU: res = l + r;
            OP_SUBU: res = l - r;
            OP_SLT:  res = {31'd0, (l ^ 32'h80000000) < (r ^ 32'h80000000)};
            OP_SLTU: res = {31'd0, l < r};
            OP_SLL:  res = r << l[4:0];
            OP_SRL:  res = r >> l[4:0];
            OP_SRA:  res = (r >> l[4:0]) | (r[31] ? ~(32'hFFFFFFFF >> l[4:0]) : 32'd0);
            OP_MFHI: res = m_hi;
            OP_MFLO: res = m_lo;
            default: we = 1'b0;
        endcase
    endfunction

    function automatic void model_hilo(input logic [5:0] op, input logic [31:0] l, input logic [31:0] r);
        longint a, b, q, p;
        case (op)
            OP_MULT: begin
                p = longint'($signed(l)) * longint'($signed(r));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = longint'({32'd0, l}) * longint'({32'd0, r});
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_DIV, OP_DIVU: if (DIV_EN && r != 32'd0) begin
                a = (op == OP_DIV) ? longint'($signed(l)) : longint'({32'd0, l});
                b = (op == OP_DIV) ? longint'($signed(r)) : longint'({32'd0, r});
                q = a / b;
                p = a % b;
                m_lo = q[31:0]; m_hi = p[31:0];
            end
            OP_MTHI: m_hi = l;
            OP_MTLO: m_lo = l;
            default: ;
        endcase
    endfunction

    // Present one instruction, check its EX cycle (and any divide wait), check the previous MEM capture
    task automatic issue(input logic [5:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [4:0] d, input logic st);
        logic we, dv;
        logic [31:0] res;
        logic [4:0] ed;
        bus.i_exop = op; bus.i_srcLeft = l; bus.i_srcRight = r;
        bus.i_offset = $urandom(); bus.i_dest = d; bus.i_stall = st;
        @(posedge clk); #1;
        n_vec++;
        chk("mem_dest", 32'(bus.o_memDest), 32'(exp_mdest));
        chk("mem_result", bus.o_memResult, exp_mres);
        if (st) begin
            we = 1'b0; res = 32'd0;
        end else model(op, l, r, we, res);
        ed = we ? d : 5'd0;
        dv = !st && (op == OP_DIV || op == OP_DIVU) && r != 32'd0 && DIV_EN;
        chk("ex_result", bus.o_exResult, res);
        chk("ex_we", 32'(bus.o_exWriteEnable), 32'(we));
        chk("ex_dest", 32'(bus.o_exDest), 32'(ed));
        chk("busy", 32'(bus.o_busy), 32'(dv));
        if (dv) begin
            bus.i_exop = OP_NOP; bus.i_stall = 1'b0;
            for (int i = 1; i <= 32; i++) begin
                @(posedge clk); #1;
                chk("div_busy_run", 32'(bus.o_busy), 32'd1);
                chk("div_mem_bubble", {27'd0, bus.o_memDest} | bus.o_memResult, 32'd0);
            end
            @(posedge clk); #1;
            chk("div_busy_done", 32'(bus.o_busy), 32'd0);
            chk("div_we_done", 32'(bus.o_exWriteEnable), 32'd0);
        end
        if (!st) model_hilo(op, l, r);
        exp_mdest = ed;
        exp_mres  = res;
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] l, r;
        bus.i_exop = OP_NOP; bus.i_srcLeft = 0; bus.i_srcRight = 0;
        bus.i_offset = 0; bus.i_dest = 0; bus.i_stall = 0;
        #1;
        chk("rst_ex_result", bus.o_exResult, 32'd0);
        chk("rst_ex_dest", 32'(bus.o_exDest), 32'd0);
        chk("rst_ex_we", 32'(bus.o_exWriteEnable), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_mem_dest", 32'(bus.o_memDest), 32'd0);
        chk("rst_mem_result", bus.o_memResult, 32'd0);
        chk("rst_hi", dut.r_hi, 32'd0);
        chk("rst_lo", dut.r_lo, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        issue(OP_OR, 32'h0000F0F0, 32'h00000F0F, 5'd5, 1'b0);
        issue(OP_MULT, 32'hFFFFFFFF, 32'd2, 5'd9, 1'b0);
        issue(OP_MFHI, 0, 0, 5'd1, 1'b0);
        issue(OP_MFLO, 0, 0, 5'd2, 1'b0);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 5'd9, 1'b0);
        issue(OP_MFHI, 0, 0, 5'd1, 1'b0);
        issue(OP_MFLO, 0, 0, 5'd2, 1'b0);
        issue(OP_DIVU, 32'd100, 32'd7, 5'd8, 1'b0);
        issue(OP_MFLO, 0, 0, 5'd3, 1'b0);
        issue(OP_MFHI, 0, 0, 5'd4, 1'b0);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd8, 1'b0);
        issue(OP_MFLO, 0, 0, 5'd3, 1'b0);
        issue(OP_MFHI, 0, 0, 5'd4, 1'b0);
        issue(OP_DIV, 32'd55, 32'd0, 5'd8, 1'b0);
        issue(OP_MFLO, 0, 0, 5'd3, 1'b0);
        issue(OP_MFHI, 0, 0, 5'd4, 1'b0);
        issue(OP_ADDU, 32'd10, 32'd20, 5'd6, 1'b1);
        issue(OP_ADDU, 32'd10, 32'd20, 5'd6, 1'b1);
        issue(OP_ADDU, 32'd10, 32'd20, 5'd6, 1'b0);
        issue(OP_ADDU, 32'hFFFFFFFF, 32'd1, 5'd7, 1'b0);
        issue(OP_SUBU, 32'd0, 32'd1, 5'd7, 1'b0);
        issue(OP_SLT, 32'h80000000, 32'd1, 5'd7, 1'b0);
        issue(OP_SLTU, 32'h80000000, 32'd1, 5'd7, 1'b0);
        issue(OP_SRA, 32'd31, 32'h80000000, 5'd7, 1'b0);
        issue(OP_SRL, 32'd35, 32'h80000000, 5'd7, 1'b0);
        issue(6'o07, 32'd1, 32'd2, 5'd7, 1'b0);
        issue(6'o77, 32'd1, 32'd2, 5'd7, 1'b0);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd8, 1'b0);
        issue(OP_MFLO, 0, 0, 5'd3, 1'b0);

        for (int i = 0; i < 250; i++) begin
            op = OPS[$urandom_range(0, 21)];
            l  = ($urandom_range(0, 3) == 0) ? $urandom() >> $urandom_range(0, 31) : $urandom();
            r  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 31);
            issue(op, l, r, 5'($urandom_range(0, 31)), $urandom_range(0, 7) == 0);
        end

        // abort a divide partway through RUN with an asynchronous reset
        issue(OP_MTHI, 32'h12345678, 0, 5'd0, 1'b0);
        issue(OP_MTLO, 32'h9ABCDEF0, 0, 5'd0, 1'b0);
        bus.i_exop = OP_DIVU; bus.i_srcLeft = 32'd1000; bus.i_srcRight = 32'd3; bus.i_stall = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        chk("abort_busy_start", 32'(bus.o_busy), 32'(DIV_EN));
        bus.i_exop = OP_NOP;
        repeat (11) @(posedge clk);
        #1;
`ifdef EX_DIV_EN
        chk("abort_count", 32'(dut.r_cnt), 32'd10);
        chk("abort_busy_run", 32'(bus.o_busy), 32'd1);
`endif
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.o_busy), 32'd0);
        chk("abort_hi", dut.r_hi, 32'd0);
        chk("abort_lo", dut.r_lo, 32'd0);
        chk("abort_ex_result", bus.o_exResult, 32'd0);
        chk("abort_mem_dest", 32'(bus.o_memDest), 32'd0);
`ifdef EX_DIV_EN
        chk("abort_count_clr", 32'(dut.r_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        m_hi = 0; m_lo = 0; exp_mdest = 0; exp_mres = 0;
        issue(OP_MFHI, 0, 0, 5'd4, 1'b0);
        issue(OP_DIVU, 32'd50, 32'd5, 5'd8, 1'b0);
        issue(OP_MFLO, 0, 0, 5'd3, 1'b0);
        issue(OP_NOP, 0, 0, 5'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
